pipe_field_generator: RTL
=========================

Name: pipe_field_generator

Overview:
- Multi-pipe obstacle generator for the game core. Runs up to NUM_PIPES concurrent pipes scrolling right-to-left on the 2 ms game tick.
- Spawns pipes at a fixed pixel spacing and draws gap heights from an LFSR.
- Scores each pipe the bird clears and ramps scroll speed with score.
- Feeds the VGA renderer and collision checker in place of the single-pipe generator.

Parameters:
- NUM_PIPES, 3, number of pipe slots (1..8)
- PIPE_SPACING, 260, scrolled pixels between consecutive spawns (must exceed MAX_STEP)
- SLOT_WIDTH, 60, pipe width in pixels
- X_START, 723, spawn X (639 + SLOT_WIDTH + 24 land margin)
- BIRD_HPOS, 320, bird horizontal position
- BIRD_XWIDTH, 34, bird width; score threshold T = BIRD_HPOS - BIRD_XWIDTH = 286
- Y_MIN, 270, minimum gap-bottom Y (must be >= slot height)
- Y_RANGE_W, 7, random span bits; pip_Y in [Y_MIN, Y_MIN + 2^Y_RANGE_W - 1], which must be <= 479
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value
- LEVEL_PTS, 10, points per speed level
- MAX_STEP, 3, maximum pixels moved per tick

Ports:
- clk_2ms, in, 1, 2 ms game tick clock
- rst, in, 1, asynchronous active-high reset
- state, in, 2, game state: 0 idle, 1 play, 2/3 freeze
- pip_X, out, 10*NUM_PIPES, pipe i X at bits [10i+9:10i]
- pip_Y, out, 9*NUM_PIPES, pipe i gap-bottom Y at bits [9i+8:9i]
- pip_valid, out, NUM_PIPES, pipe i active
- score, out, 8, pipes cleared, saturating at 255
- score_pulse, out, 1, one-tick strobe on each score increment
- step, out, 2, current pixels per tick (1..MAX_STEP)
- spawn_overflow, out, 1, sticky: a spawn was dropped because no slot was free

Behaviour:
- Reset, async on rst high:
  - pip_X = 0, pip_Y = Y_MIN, pip_valid = 0, score = 0, score_pulse = 0
  - step = 1, level_cnt = 0, spawn_cnt = PIPE_SPACING, lfsr = LFSR_SEED, spawn_overflow = 0
  - Reset mid-play takes effect immediately; no partial updates.
- LFSR: 16-bit Galois, taps x^16 + x^14 + x^13 + x^11 + 1. Advances every tick in every state, so idle time contributes entropy.
- state 0 (idle): same register values as reset, except the LFSR keeps running.
- state 1 (play), evaluated each tick, all updates registered in the same tick:
  - Move: each valid pipe with X >= step gets X <= X - step.
  - Retire: a valid pipe with X < step gets valid <= 0, X <= 0.
  - Score: a valid pipe with X_old > T and X_new <= T scores one point. Crossing is strict on the old value, so a pipe scores once even when step > 1.
    - score <= min(score + 1, 255); score_pulse = 1 for that tick only.
    - PIPE_SPACING > MAX_STEP guarantees at most one scoring pipe per tick.
  - Level: on each scoring event level_cnt increments. When it reaches LEVEL_PTS it wraps to 0 and step <= min(step + 1, MAX_STEP). The new step applies from the next tick.
  - Spawn counter: spawn_cnt <= spawn_cnt + step. When spawn_cnt + step >= PIPE_SPACING, instead:
    - the lowest-index free slot gets X = X_START, Y = Y_MIN + lfsr[Y_RANGE_W-1:0], valid = 1;
    - spawn_cnt <= 0.
  - Because spawn_cnt reset value is PIPE_SPACING, the first play tick spawns into slot 0.
  - No free slot (a retire in the same tick does not count as free): the spawn is dropped, spawn_cnt <= 0, spawn_overflow <= 1 until reset or state 0.
  - A freshly spawned pipe does not move on its spawn tick.
- state 2/3 (freeze): all outputs hold; score_pulse = 0; only the LFSR advances. Returning to state 1 resumes exactly where play stopped.
- Width rules:
  - X arithmetic in 10 bits, never underflows (retire guard).
  - Y sum fits in 9 bits given the parameter constraints.
  - spawn_cnt is 10 bits.

Test Plan:
- rst pulse mid-play with 2 pipes valid -> same cycle: pip_valid = 0, score = 0, step = 1, lfsr = 16'hACE1.
- state 0 -> 1 -> first tick: slot 0 valid, X = 723, Y in [270, 397]. After 260 further ticks at step 1: slot 1 spawns, slot 0 X = 463.
- Single pipe run at step 1 -> score 0 -> 1 exactly on the tick X goes 287 -> 286, score_pulse high for one tick. Pipe retires at X = 0 the following tick after reaching 0.
- Force step = 3 with a pipe at X = 288 -> X = 285, score +1 once. Next tick (X = 282) gives no further increment.
- Play to 10 points -> step 2 from the next tick. Play to 20 points -> step 3. At 30 points step stays 3. score saturates at 255 with no wrap.
- NUM_PIPES = 1, PIPE_SPACING = 100 -> second spawn finds slot busy: spawn_overflow = 1, slot 0 unchanged. state = 2 for 50 ticks: pip_X constant, then resumes.

Source files
------------

// File: rtl/pipe_field_generator.sv
// pipe_field_generator: scrolling multi-slot pipe field for the game core.
// Spawns pipes on a scrolled-distance counter, draws gap heights from a
// Galois LFSR, scores each pipe the bird clears and ramps scroll speed
// every LEVEL_PTS points.
module pipe_field_generator #(
  parameter int          NUM_PIPES    = 3,
  parameter int          PIPE_SPACING = 260,
  parameter int          SLOT_WIDTH   = 60,
  parameter int          X_START      = 723,
  parameter int          BIRD_HPOS    = 320,
  parameter int          BIRD_XWIDTH  = 34,
  parameter int          Y_MIN        = 270,
  parameter int          Y_RANGE_W    = 7,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          LEVEL_PTS    = 10,
  parameter int          MAX_STEP     = 3
) (
  input  logic                     clk_2ms,
  input  logic                     rst,
  input  logic [1:0]               state,
  output logic [10*NUM_PIPES-1:0]  pip_X,
  output logic [9*NUM_PIPES-1:0]   pip_Y,
  output logic [NUM_PIPES-1:0]     pip_valid,
  output logic [7:0]               score,
  output logic                     score_pulse,
  output logic [1:0]               step,
  output logic                     spawn_overflow
);

  localparam logic [9:0]  X_SPAWN    = 10'(X_START);
  localparam logic [9:0]  SCORE_T    = 10'(BIRD_HPOS - BIRD_XWIDTH);
  localparam logic [10:0] SPACING    = 11'(PIPE_SPACING);
  localparam logic [8:0]  Y_BASE     = 9'(Y_MIN);
  localparam logic [1:0]  STEP_MAX   = 2'(MAX_STEP);
  localparam logic [7:0]  LEVEL_LAST = 8'(LEVEL_PTS - 1);
  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_PLAY    = 2'd1;

  // Reject parameter sets that would break the one-score-per-tick or
  // off-screen spawn assumptions, or overflow the 9-bit gap height.
  if (PIPE_SPACING <= MAX_STEP || X_START < 640 + SLOT_WIDTH ||
      Y_MIN + (2 ** Y_RANGE_W) - 1 > 479) begin : g_bad_params
    $error("pipe_field_generator: inconsistent parameter set");
  end

  logic [9:0]           pipeX_q [NUM_PIPES];
  logic [9:0]           pipeX_d [NUM_PIPES];
  logic [8:0]           pipeY_q [NUM_PIPES];
  logic [8:0]           pipeY_d [NUM_PIPES];
  logic [NUM_PIPES-1:0] pipeValid_q, pipeValid_d;
  logic [7:0]           score_q, score_d;
  logic                 pulse_q, pulse_d;
  logic [1:0]           step_q, step_d;
  logic [7:0]           levelCnt_q, levelCnt_d;
  logic [9:0]           spawnCnt_q, spawnCnt_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 overflow_q, overflow_d;

  logic [9:0]           stepWide;
  logic [10:0]          spawnSum;
  logic                 scoreHit;
  logic                 slotTaken;

  // Next-state logic: LFSR always runs; idle clears, play moves/scores/spawns, freeze holds.
  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    pipeX_d     = pipeX_q;
    pipeY_d     = pipeY_q;
    pipeValid_d = pipeValid_q;
    score_d     = score_q;
    pulse_d     = 1'b0;
    step_d      = step_q;
    levelCnt_d  = levelCnt_q;
    spawnCnt_d  = spawnCnt_q;
    overflow_d  = overflow_q;
    stepWide    = {8'd0, step_q};
    spawnSum    = {1'b0, spawnCnt_q} + {9'd0, step_q};
    scoreHit    = 1'b0;
    slotTaken   = 1'b0;
    case (state)
      ST_IDLE: begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          pipeX_d[i] = '0;
          pipeY_d[i] = Y_BASE;
        end
        pipeValid_d = '0;
        score_d     = '0;
        step_d      = 2'd1;
        levelCnt_d  = '0;
        spawnCnt_d  = SPACING[9:0];
        overflow_d  = 1'b0;
      end
      ST_PLAY: begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (pipeValid_q[i]) begin
            if (pipeX_q[i] >= stepWide) begin
              pipeX_d[i] = pipeX_q[i] - stepWide;
              if (pipeX_q[i] > SCORE_T && (pipeX_q[i] - stepWide) <= SCORE_T)
                scoreHit = 1'b1;
            end else begin
              pipeValid_d[i] = 1'b0;
              pipeX_d[i]     = '0;
            end
          end
        end
        if (spawnSum >= SPACING) begin
          spawnCnt_d = '0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (!slotTaken && !pipeValid_q[i]) begin
              slotTaken      = 1'b1;
              pipeX_d[i]     = X_SPAWN;
              pipeY_d[i]     = Y_BASE + 9'(lfsr_q[Y_RANGE_W-1:0]);
              pipeValid_d[i] = 1'b1;
            end
          end
          if (!slotTaken)
            overflow_d = 1'b1;
        end else begin
          spawnCnt_d = spawnSum[9:0];
        end
        if (scoreHit) begin
          pulse_d = 1'b1;
          if (score_q != 8'hFF)
            score_d = score_q + 8'd1;
          if (levelCnt_q >= LEVEL_LAST) begin
            levelCnt_d = '0;
            if (step_q < STEP_MAX)
              step_d = step_q + 2'd1;
          end else begin
            levelCnt_d = levelCnt_q + 8'd1;
          end
        end
      end
      default: begin
        pulse_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset to the idle values and the LFSR seed.
  always_ff @(posedge clk_2ms or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipeX_q[i] <= '0;
        pipeY_q[i] <= Y_BASE;
      end
      pipeValid_q <= '0;
      score_q     <= '0;
      pulse_q     <= 1'b0;
      step_q      <= 2'd1;
      levelCnt_q  <= '0;
      spawnCnt_q  <= SPACING[9:0];
      lfsr_q      <= LFSR_SEED;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipeX_q[i] <= pipeX_d[i];
        pipeY_q[i] <= pipeY_d[i];
      end
      pipeValid_q <= pipeValid_d;
      score_q     <= score_d;
      pulse_q     <= pulse_d;
      step_q      <= step_d;
      levelCnt_q  <= levelCnt_d;
      spawnCnt_q  <= spawnCnt_d;
      lfsr_q      <= lfsr_d;
      overflow_q  <= overflow_d;
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign pip_X[10*g +: 10] = pipeX_q[g];
    assign pip_Y[9*g +: 9]   = pipeY_q[g];
  end

  assign pip_valid      = pipeValid_q;
  assign score          = score_q;
  assign score_pulse    = pulse_q;
  assign step           = step_q;
  assign spawn_overflow = overflow_q;

endmodule
